// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the CPU core sequencer.
//   seq_state_t : sequencer phase/state encoding
//   STP_OPCODE  : 6-bit opcode of the STP (stop) instruction
//   CW_DEFAULT  : default width of the cycle/instruction counters
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC1 = 3'd2,
    ST_EXEC2 = 3'd3,
    ST_HALT  = 3'd4,
    ST_FAULT = 3'd5
  } seq_state_t;

  localparam logic [5:0] STP_OPCODE = 6'b111111;
  localparam int         CW_DEFAULT = 16;

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: control, instruction-RAM and decoder signals of the
// phase sequencer.
//   master: drives run/step/halt_req/clear, ram_ready/instr_in, E2/stop;
//           observes the phase strobes, instr, status and counters.
//   slave : the sequencer side (opposite directions).
interface cpu_sequencer_if #(
  parameter int CW = cpu_pkg::CW_DEFAULT
);
  logic          run;
  logic          step;
  logic          halt_req;
  logic          clear;
  logic          ram_ready;
  logic [15:0]   instr_in;
  logic          E2;
  logic          stop;
  logic          FETCH;
  logic          EXEC1;
  logic          EXEC2;
  logic [15:0]   instr;
  logic          idle;
  logic          halted;
  logic          fault;
  logic [CW-1:0] cycle_count;
  logic [CW-1:0] instr_count;

  modport master (
    output run, step, halt_req, clear, ram_ready, instr_in, E2, stop,
    input  FETCH, EXEC1, EXEC2, instr, idle, halted, fault,
           cycle_count, instr_count
  );

  modport slave (
    input  run, step, halt_req, clear, ram_ready, instr_in, E2, stop,
    output FETCH, EXEC1, EXEC2, instr, idle, halted, fault,
           cycle_count, instr_count
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones.
//   clk, rst_n : clock, asynchronous active-low reset (clears to 0)
//   en         : count enable for this cycle
//   q          : registered count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
  localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};

  // Count register: advance when enabled and not yet saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en && (q != ALL_ONES)) begin
      q <= q + ONE;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: FETCH/EXEC1/EXEC2 phase sequencer with run/step/halt
// control, STP stop, fetch wait-state timeout and saturating counters.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : cpu_sequencer_if.slave (control in, RAM data in, decoder
//                E2/stop in; phase strobes, instr, status, counters out)
// Parameters: CW counter width, WAIT_MAX (1..15) fetch cycles without
// ram_ready before FAULT.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int CW       = CW_DEFAULT,
  parameter int WAIT_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  cpu_sequencer_if.slave   bus
);

  // Last wait count before timeout: the next ready-less FETCH cycle faults.
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_MAX - 1);

  seq_state_t     r_state;
  seq_state_t     w_next;
  logic [3:0]     r_wait;
  logic [3:0]     w_wait_next;
  logic           r_single_step;
  logic           w_ss_next;
  logic [15:0]    r_instr;
  logic [15:0]    w_instr_next;
  logic           w_retire;
  logic           w_active;
  logic           w_end_to_idle;
  logic           r_fetch;
  logic           r_exec1;
  logic           r_exec2;
  logic           r_idle;
  logic           r_halted;
  logic           r_fault;
  logic [CW-1:0]  w_cycle_q;
  logic [CW-1:0]  w_instr_q;

  // At an instruction boundary, any of these sends the core back to IDLE.
  assign w_end_to_idle = bus.halt_req | r_single_step | ~bus.run;
  assign w_active      = (r_state == ST_FETCH) || (r_state == ST_EXEC1) ||
                         (r_state == ST_EXEC2);

  // Next-state, wait counter, single-step flag and instruction latch.
  always_comb begin
    w_next       = r_state;
    w_wait_next  = 4'd0;
    w_ss_next    = r_single_step;
    w_instr_next = r_instr;
    w_retire     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.halt_req) begin
          w_next = ST_IDLE;
        end else if (bus.run) begin
          w_next    = ST_FETCH;
          w_ss_next = 1'b0;
        end else if (bus.step) begin
          w_next    = ST_FETCH;
          w_ss_next = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (bus.ram_ready) begin
          w_instr_next = bus.instr_in;
          w_next       = ST_EXEC1;
        end else if (r_wait == WAIT_LAST) begin
          w_next = ST_FAULT;
        end else begin
          w_wait_next = r_wait + 4'd1;
        end
      end
      ST_EXEC1: begin
        if (bus.stop) begin
          // STP retires as it halts, regardless of E2 or halt_req.
          w_retire = 1'b1;
          w_next   = ST_HALT;
        end else if (bus.E2) begin
          w_next = ST_EXEC2;
        end else begin
          w_retire = 1'b1;
          if (w_end_to_idle) begin
            w_next    = ST_IDLE;
            w_ss_next = 1'b0;
          end else begin
            w_next = ST_FETCH;
          end
        end
      end
      ST_EXEC2: begin
        w_retire = 1'b1;
        if (w_end_to_idle) begin
          w_next    = ST_IDLE;
          w_ss_next = 1'b0;
        end else begin
          w_next = ST_FETCH;
        end
      end
      ST_HALT: begin
        if (bus.clear) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_HALT;
        end
      end
      ST_FAULT: begin
        if (bus.clear) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_FAULT;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // State, local counters and registered outputs decoded from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_wait        <= 4'd0;
      r_single_step <= 1'b0;
      r_instr       <= 16'h0000;
      r_fetch       <= 1'b0;
      r_exec1       <= 1'b0;
      r_exec2       <= 1'b0;
      r_idle        <= 1'b1;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_wait        <= w_wait_next;
      r_single_step <= w_ss_next;
      r_instr       <= w_instr_next;
      r_fetch       <= (w_next == ST_FETCH);
      r_exec1       <= (w_next == ST_EXEC1);
      r_exec2       <= (w_next == ST_EXEC2);
      r_idle        <= (w_next == ST_IDLE);
      r_halted      <= (w_next == ST_HALT);
      r_fault       <= (w_next == ST_FAULT);
    end
  end

  sat_counter #(.W(CW)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_active),
    .q     (w_cycle_q)
  );

  sat_counter #(.W(CW)) u_instr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_retire),
    .q     (w_instr_q)
  );

  assign bus.FETCH       = r_fetch;
  assign bus.EXEC1       = r_exec1;
  assign bus.EXEC2       = r_exec2;
  assign bus.instr       = r_instr;
  assign bus.idle        = r_idle;
  assign bus.halted      = r_halted;
  assign bus.fault       = r_fault;
  assign bus.cycle_count = w_cycle_q;
  assign bus.instr_count = w_instr_q;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Phase sequencer for the 16-bit CPU core: generates the one-hot FETCH / EXEC1 / EXEC2 phase strobes consumed by the instruction decoder, and latches the fetched word into the instruction register. Also handles run/step/halt control, the STP stop condition, instruction-RAM wait states with a timeout fault, and saturating cycle and instruction counters. Sits between the instruction RAM and the decoder, alongside the program counter.

## Interface
- CW, 16: width of cycle_count and instr_count.
- WAIT_MAX, 4: maximum FETCH cycles without ram_ready before fault; legal range 1..15.

- clk  in  1  single core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  level; start/continue free-running execution.
- step  in  1  execute exactly one instruction from IDLE.
- halt_req  in  1  level; stop at the next instruction boundary.
- clear  in  1  leave HALT/FAULT and return to IDLE.
- ram_ready  in  1  instruction RAM data valid on instr_in this cycle.
- instr_in  in  16  instruction RAM read data.
- E2  in  1  decoder: instruction needs a second execute cycle; sampled only in EXEC1.
- stop  in  1  decoder: current instruction is STP; sampled only in EXEC1.
- FETCH, EXEC1, EXEC2  out  1 each  phase strobes, at most one high.
- instr  out  16  instruction register, feeds the decoder.
- idle, halted, fault  out  1 each  status.
- cycle_count  out  CW  active cycles since reset.
- instr_count  out  CW  retired instructions since reset.

## Operation
- States: IDLE, FETCH, EXEC1, EXEC2, HALT, FAULT.
- All outputs are registered and decoded from the state register.
- Reset values:
  - state = IDLE, so idle=1 and all phase strobes = 0.
  - instr = 16'h0000.
  - both counters = 0.
  - halted = 0, fault = 0.
- IDLE:
  - halt_req=1: stay in IDLE (highest priority).
  - else run=1: go to FETCH.
  - else step=1: go to FETCH and set single_step flag.
- FETCH:
  - ram_ready=1: load instr <= instr_in; go to EXEC1.
  - else: increment wait counter. When it would reach WAIT_MAX, go to FAULT.
  - Wait counter clears on every entry to FETCH.
- EXEC1, in priority order:
  1. stop=1: go to HALT. Takes priority over E2 and halt_req.
  2. E2=1: go to EXEC2.
  3. Otherwise this is a boundary (see below).
- EXEC2: always a boundary.
- Boundary: retire the instruction (instr_count++), then:
  - halt_req or single_step or run=0: go to IDLE and clear single_step.
  - else: go to FETCH.
- STP retires (instr_count++) on its transition to HALT.
- HALT: stay until clear=1, then go to IDLE. halted=1 while in HALT.
- FAULT: stay until clear=1, then go to IDLE. fault=1 while in FAULT.
- clear is ignored in all other states.
- Counters:
  - cycle_count increments in FETCH, EXEC1 and EXEC2.
  - Both counters saturate at all-ones and never wrap.
  - Neither counter is reset by clear.
- instr holds its value outside FETCH; it changes only on a FETCH cycle with ram_ready=1.

## Timing
- Zero-wait fetch (ram_ready high in the first FETCH cycle): 2 cycles per single-cycle instruction, 3 cycles per E2 instruction.
- Each cycle with ram_ready=0 adds one FETCH cycle.
- Run from IDLE: FETCH is high the cycle after run is sampled high.
- instr is valid from the first EXEC1 cycle onward. E2 and stop must settle combinationally within EXEC1.
- halt_req asserted mid-instruction: the instruction completes, and IDLE is entered the cycle after the boundary.
- Reset is asynchronous: an assertion mid-FETCH or mid-EXEC2 forces IDLE immediately and abandons the instruction uncounted.
- Reset deassertion is synchronised externally; the block itself has no synchroniser.

## Structure
- Shared package cpu_pkg holds:
  - the state enum (seq_state_t);
  - the STP opcode constant 6'b111111;
  - the default CW.
- Sub-module sat_counter (parameter W; ports en, q), instantiated twice for cycle_count and instr_count.
- Wait counter and single_step flag are local to cpu_sequencer.

## Test plan
- Zero-wait run:
  - Stimulus: run=1, ram_ready=1, three non-E2 instructions, then run=0.
  - Response: phase pattern F,E1,F,E1,F,E1 then IDLE; instr_count=3; cycle_count=6.
- E2 plus wait states:
  - Stimulus: ram_ready low for 2 cycles, then instr_in=16'h3800 (MUL, E2=1).
  - Response: F,F,F,E1,E2; instr=16'h3800 from EXEC1; instr_count=1.
- Single step:
  - Stimulus: step pulse in IDLE with run=0.
  - Response: exactly one F,E1 sequence, then IDLE with idle=1; a second step executes the next instruction.
- Halt versus stop:
  - Stimulus: halt_req raised during EXEC1 of an E2 instruction.
  - Response: EXEC2 completes, then IDLE.
  - Stimulus: stop=1 in EXEC1 together with E2=1 and halt_req=1.
  - Response: HALT with halted=1; clear returns to IDLE.
- Fetch timeout:
  - Stimulus: WAIT_MAX=4, ram_ready held 0.
  - Response: FAULT after 4 FETCH cycles with fault=1, instr unchanged, instr_count unchanged.
- Saturation and reset:
  - Stimulus: CW=4, 20 instructions.
  - Response: instr_count holds at 4'hF.
  - Stimulus: rst_n pulsed low in EXEC2.
  - Response: immediate IDLE, all outputs at their reset values.
